full_adder: RTL and testbench

- Registered binary adder with carry-in. The default WIDTH=1 makes it a single-bit full adder; wider instances form a carry-lookahead word adder.
- Used as the arithmetic leaf in datapath blocks, and as the reference cell for the adder truth-table bench.
- Inputs are sampled on the rising clock edge. Results appear one cycle later with a valid flag.

---
 rtl/full_adder.sv | 130 +++++++++++++
 tb/tb_full_adder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered adder with carry-in: single-bit full adder at WIDTH=1, carry-
// lookahead word adder when wider. One cycle of latency, no backpressure.

// Lookahead cell for one group of up to GW bits: every internal carry is a
// flat sum-of-products of the group inputs, plus group propagate/generate
// so groups can be chained.
module fa_cla_group #(
  parameter int GW = 4
) (
  input  logic [GW-1:0] p,
  input  logic [GW-1:0] g,
  input  logic          ci,
  output logic [GW-1:0] c,
  output logic          pg,
  output logic          gg
);

  // Carry into bit i = ci&p[i-1:0] | OR over j<i of g[j]&p[i-1:j+1].
  always_comb begin
    logic t;
    logic acc;
    t   = 1'b0;
    acc = 1'b0;
    c   = '0;
    for (int i = 0; i < GW; i++) begin
      t = ci;
      for (int k = 0; k < i; k++) t = t & p[k];
      acc = t;
      for (int j = 0; j < i; j++) begin
        t = g[j];
        for (int k = j + 1; k < i; k++) t = t & p[k];
        acc = acc | t;
      end
      c[i] = acc;
    end
  end

  // Group generate: some bit generates and every bit above it propagates.
  always_comb begin
    logic t;
    t  = 1'b0;
    gg = 1'b0;
    for (int j = 0; j < GW; j++) begin
      t = g[j];
      for (int k = j + 1; k < GW; k++) t = t & p[k];
      gg = gg | t;
    end
    pg = &p;
  end

endmodule

module full_adder #(
  parameter int WIDTH = 1,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             prop,
  output logic             gen,
  output logic             out_valid
);

  // Last group is partial when WIDTH is not a multiple of GROUP.
  localparam int NG = (WIDTH + GROUP - 1) / GROUP;

  logic [WIDTH-1:0] p, g;
  logic [NG-1:0]    grp_p, grp_g;
  logic [NG:0]      cg;   // carry into each group, chain seeded with cin
  logic [NG:0]      cz;   // same chain seeded with 0, yields word generate
  logic [WIDTH:0]   c;    // carry into each bit, c[WIDTH] is carry-out

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int LO = k * GROUP;
    localparam int GW = (WIDTH - LO < GROUP) ? (WIDTH - LO) : GROUP;
    fa_cla_group #(.GW(GW)) u_grp (
      .p  (p[LO +: GW]),
      .g  (g[LO +: GW]),
      .ci (cg[k]),
      .c  (c[LO +: GW]),
      .pg (grp_p[k]),
      .gg (grp_g[k])
    );
  end

  // Second level: combine group P/G into group carries, once with the real
  // carry-in and once with zero so gen is available for cascading.
  always_comb begin
    cg[0] = cin;
    cz[0] = 1'b0;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = grp_g[k] | (grp_p[k] & cg[k]);
      cz[k+1] = grp_g[k] | (grp_p[k] & cz[k]);
    end
  end

  assign c[WIDTH] = cg[NG];

  // Datapath only loads on valid input; valid flag tracks in_valid each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      prop      <= 1'b0;
      gen       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= p ^ c[WIDTH-1:0];
        c_out <= c[WIDTH];
        ovf   <= c[WIDTH] ^ c[WIDTH-1];
        prop  <= &p;
        gen   <= cz[NG];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH=1, 8 and 13 (partial last group). Stimulus
// pushes expected results into per-instance queues; monitors pop on out_valid.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] sum;
    logic [3:0]  fl;   // {c_out, ovf, prop, gen}
  } exp_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // WIDTH=1
  logic        v1 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic        s1, co1, ov1, pr1, gn1, ov_1;
  // WIDTH=8
  logic        v8 = 0, c8 = 0;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        co8, ov8, pr8, gn8, ov_8;
  // WIDTH=13, GROUP=4
  logic        v13 = 0, c13 = 0;
  logic [12:0] a13 = 0, b13 = 0, s13;
  logic        co13, ov13, pr13, gn13, ov_13;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum(s1), .c_out(co1), .ovf(ov1), .prop(pr1), .gen(gn1), .out_valid(ov_1));

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .sum(s8), .c_out(co8), .ovf(ov8), .prop(pr8), .gen(gn8), .out_valid(ov_8));

  full_adder #(.WIDTH(13), .GROUP(4)) u_w13 (
    .clk(clk), .rst(rst), .in_valid(v13), .a(a13), .b(b13), .cin(c13),
    .sum(s13), .c_out(co13), .ovf(ov13), .prop(pr13), .gen(gn13), .out_valid(ov_13));

  exp_t q1[$], q8[$], q13[$];
  exp_t e1, e8, e13;
  int   n1 = 0, n8 = 0, n13 = 0, sent13 = 0;

  // Monitors: sample on the falling edge, pop one expectation per valid beat.
  always @(negedge clk) if (ov_1 === 1'b1) begin
    if (q1.size() == 0) begin
      errors++;
      $display("FAIL w1 unexpected out_valid: got 1 expected 0");
    end else begin
      e1 = q1.pop_front();
      n1++;
      chk("w1 sum", 64'(s1), e1.sum);
      chk("w1 flags", {60'b0, co1, ov1, pr1, gn1}, {60'b0, e1.fl});
    end
  end

  always @(negedge clk) if (ov_8 === 1'b1) begin
    if (q8.size() == 0) begin
      errors++;
      $display("FAIL w8 unexpected out_valid: got 1 expected 0");
    end else begin
      e8 = q8.pop_front();
      n8++;
      chk("w8 sum", 64'(s8), e8.sum);
      chk("w8 flags", {60'b0, co8, ov8, pr8, gn8}, {60'b0, e8.fl});
    end
  end

  always @(negedge clk) if (ov_13 === 1'b1) begin
    if (q13.size() == 0) begin
      errors++;
      $display("FAIL w13 unexpected out_valid: got 1 expected 0");
    end else begin
      e13 = q13.pop_front();
      n13++;
      chk("w13 sum", 64'(s13), e13.sum);
      chk("w13 flags", {60'b0, co13, ov13, pr13, gn13}, {60'b0, e13.fl});
    end
  end

  // Reference for WIDTH=13: 14-bit add, overflow from operand/result signs.
  function automatic exp_t model13(input logic [12:0] a, input logic [12:0] b, input logic ci);
    exp_t r;
    logic [13:0] f, f0;
    logic        o;
    f  = {1'b0, a} + {1'b0, b} + {13'b0, ci};
    f0 = {1'b0, a} + {1'b0, b};
    o  = (a[12] == b[12]) && (f[12] != a[12]);
    r.sum = {51'b0, f[12:0]};
    r.fl  = {f[13], o, &(a ^ b), f0[13]};
    return r;
  endfunction

  // {a, b, cin, sum, c_out, ovf, prop, gen}, hand-computed
  logic [7:0] tt [8] = '{
    8'b000_0_0_0_0_0, 8'b001_1_0_1_0_0, 8'b010_1_0_0_1_0, 8'b100_1_0_0_1_0,
    8'b011_0_1_0_1_0, 8'b101_0_1_0_1_0, 8'b110_0_1_1_0_1, 8'b111_1_1_0_0_1
  };

  // {a, b, cin, sum, {c_out, ovf, prop, gen}}
  logic [28:0] v8tab [4] = '{
    {8'hFF, 8'h00, 1'b1, 8'h00, 4'b1010},
    {8'h7F, 8'h01, 1'b0, 8'h80, 4'b0100},
    {8'h80, 8'h80, 1'b0, 8'h00, 4'b1101},
    {8'h03, 8'h04, 1'b0, 8'h07, 4'b0000}
  };

  logic [12:0] da [3] = '{13'h1FFF, 13'h0FFF, 13'h1000};
  logic [12:0] db [3] = '{13'h0000, 13'h0001, 13'h1000};
  logic        dc [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    exp_t x;
    logic [31:0] r;

    // Reset state of all instances.
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst w1 sum", 64'(s1), 64'h0);
    chk("rst w1 flags", {59'b0, co1, ov1, pr1, gn1, ov_1}, 64'h0);
    chk("rst w8 sum", 64'(s8), 64'h0);
    chk("rst w8 flags", {59'b0, co8, ov8, pr8, gn8, ov_8}, 64'h0);
    chk("rst w13 sum", 64'(s13), 64'h0);
    chk("rst w13 flags", {59'b0, co13, ov13, pr13, gn13, ov_13}, 64'h0);
    rst = 1'b0;

    // WIDTH=1 truth table, back to back.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      v1 = 1'b1; {a1, b1, c1} = tt[i][7:5];
      x.sum = {63'b0, tt[i][4]}; x.fl = tt[i][3:0];
      q1.push_back(x);
    end

    // Reset with valid input held: reset wins for two edges.
    @(posedge clk); #1;
    rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      chk("rst-valid w1 sum", 64'(s1), 64'h0);
      chk("rst-valid w1 flags", {59'b0, co1, ov1, pr1, gn1, ov_1}, 64'h0);
    end
    rst = 1'b0;
    x.sum = 64'h1; x.fl = 4'b1001;
    q1.push_back(x);
    @(posedge clk); #1;
    v1 = 1'b0;

    // WIDTH=8 wrap, signed overflow, then a vector that must hold.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      v8 = 1'b1; {a8, b8, c8} = v8tab[i][28:12];
      x.sum = {56'b0, v8tab[i][11:4]}; x.fl = v8tab[i][3:0];
      q8.push_back(x);
    end
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("w8 hold sum", 64'(s8), 64'h07);
      chk("w8 hold out_valid", 64'(ov_8), 64'h0);
    end

    // WIDTH=13: directed corners then random vectors with random gaps.
    for (int i = 0; i < 1003; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        v13 = 1'b1; a13 = da[i]; b13 = db[i]; c13 = dc[i];
      end else begin
        r = $urandom; a13 = r[12:0];
        r = $urandom; b13 = r[12:0]; c13 = r[13];
        v13 = (r[17:16] != 2'b00);
      end
      if (v13) begin
        q13.push_back(model13(a13, b13, c13));
        sent13++;
      end
    end
    @(posedge clk); #1;
    v13 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    chk("w1 beats", 64'(n1), 64'd9);
    chk("w8 beats", 64'(n8), 64'd4);
    chk("w13 beats", 64'(n13), 64'(sent13));
    chk("queues drained", 64'(q1.size() + q8.size() + q13.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
